// File: rtl/ext_bridge.sv
// ext_bridge: converts cache external-port single and burst transactions
// into single-beat 64-bit memory accesses and returns read beats to the
// cache, in order, through a small reply FIFO. The ext side advances only
// on clk edges with phi2=1; the memory side advances on every clk edge.
module ext_bridge #(
   parameter int RQDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        phi2,
   input  logic [31:0] extaddr,
   input  logic [63:0] extwdata,
   input  logic [4:0]  extsz,
   input  logic        extreq,
   input  logic        extwr,
   input  logic        extsrc,
   output logic        extrdy,
   output logic        extreply,
   output logic        extreplyto,
   output logic [63:0] extrdata,
   output logic        exterror,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   input  logic        mem_rerr,
   output logic        werr
);

   localparam int AW = $clog2(RQDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTHV = (CW+1)'(RQDEPTH);

   typedef enum logic [1:0] {IDLE, WDATA2, ISSUE} state_t;

   state_t state, next_state;

   // command slot
   logic [31:0] addr;
   logic [4:0]  sz;
   logic        wr, src, bad;
   logic [63:0] wbuf0, wbuf1;
   logic [1:0]  bc;

   // reply FIFO and read-tag queue
   logic [63:0]        rq_data [RQDEPTH];
   logic [RQDEPTH-1:0] rq_err, rq_src, tagq;
   logic [AW-1:0]      rq_wp, rq_rp, tag_wp, tag_rp, err_idx;
   logic [CW-1:0]      rq_count, inflight;

   logic credit, ext_acc, wdata2_acc, cmd_bad, last_beat;
   logic grant, read_grant, rvalid_eff, err_push, err_src, pop;
   logic [2:0] shamt;
   logic [7:0] strb;

   function automatic logic is_legal(input logic [2:0] off, input logic [4:0] s);
      return (s == 5'd15) || (s == 5'd31) ||
             ((s <= 5'd7) && (({1'b0, off} + {1'b0, s[2:0]}) <= 4'd7));
   endfunction

   // Handshake qualifiers, read credit and FIFO push/pop conditions
   always_comb begin
      credit     = ({1'b0, rq_count} + {1'b0, inflight}) < DEPTHV;
      ext_acc    = phi2 && extreq && (state == IDLE);
      wdata2_acc = phi2 && extreq && extwr && (state == WDATA2);
      cmd_bad    = !is_legal(extaddr[2:0], extsz);
      last_beat  = (sz == 5'd31) ? (bc == 2'd3) :
                   (sz == 5'd15) ? (bc == 2'd1) : 1'b1;
      extrdy     = (state == IDLE) || (state == WDATA2);
      mem_req    = ((state == ISSUE) && !bad && (wr || credit)) ||
                   ((state == WDATA2) && (bc == 2'd0));
      grant      = mem_req && mem_gnt;
      read_grant = grant && !wr;
      rvalid_eff = mem_rvalid && (inflight != '0);
      err_push   = (ext_acc && !extwr && cmd_bad && credit) ||
                   ((state == ISSUE) && bad && credit);
      err_src    = (state == IDLE) ? extsrc : src;
      err_idx    = rq_wp + AW'(rvalid_eff);
      pop        = phi2 && (rq_count != '0);
      extreply   = (rq_count != '0);
      extrdata   = rq_data[rq_rp];
      exterror   = rq_err[rq_rp];
      extreplyto = rq_src[rq_rp];
   end

   // Memory beat fields: critical-word-first address and lane-aligned data
   always_comb begin
      mem_we    = wr;
      shamt     = 3'd7 - sz[2:0] - addr[2:0];
      strb      = 8'hFF >> (3'd7 - sz[2:0]);
      mem_addr  = {addr[31:3], 3'b000};
      mem_wdata = 64'h0;
      mem_wstrb = 8'h00;
      if (sz == 5'd15)
         mem_addr = {addr[31:4], addr[3] ^ bc[0], 3'b000};
      else if (sz == 5'd31)
         mem_addr = {addr[31:5], addr[4:3] + bc, 3'b000};
      if (wr) begin
         if (sz[4:3] != 2'b00) begin
            mem_wdata = bc[0] ? wbuf1 : wbuf0;
            mem_wstrb = 8'hFF;
         end else begin
            mem_wdata = wbuf0 << {shamt, 3'b000};
            mem_wstrb = strb << shamt;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state: capture, second write beat, issue until last grant
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (ext_acc) begin
               if (cmd_bad)
                  next_state = (!extwr && !credit) ? ISSUE : IDLE;
               else if (extwr && (extsz == 5'd15))
                  next_state = WDATA2;
               else
                  next_state = ISSUE;
            end
         end
         WDATA2: if (wdata2_acc) next_state = ISSUE;
         ISSUE: begin
            if (bad) begin
               if (credit) next_state = IDLE;
            end else if (grant && last_beat) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Command slot capture, beat counter and malformed-write pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr  <= '0;
         sz    <= '0;
         wr    <= 1'b0;
         src   <= 1'b0;
         bad   <= 1'b0;
         wbuf0 <= '0;
         wbuf1 <= '0;
         bc    <= '0;
         werr  <= 1'b0;
      end else begin
         werr <= ext_acc && extwr && cmd_bad;
         if (ext_acc) begin
            addr  <= extaddr;
            sz    <= extsz;
            wr    <= extwr;
            src   <= extsrc;
            bad   <= cmd_bad;
            wbuf0 <= extwdata;
            bc    <= '0;
         end
         if (wdata2_acc) wbuf1 <= extwdata;
         if (grant)      bc <= bc + 2'd1;
      end
   end

   // Outstanding-read count, source tags, reply FIFO pointers and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
         tagq     <= '0;
         tag_wp   <= '0;
         tag_rp   <= '0;
         rq_err   <= '0;
         rq_src   <= '0;
         rq_wp    <= '0;
         rq_rp    <= '0;
         rq_count <= '0;
      end else begin
         if (read_grant && !rvalid_eff)      inflight <= inflight + CW'(1);
         else if (!read_grant && rvalid_eff) inflight <= inflight - CW'(1);
         if (read_grant) begin
            tagq[tag_wp] <= src;
            tag_wp       <= tag_wp + AW'(1);
         end
         if (rvalid_eff) begin
            tag_rp        <= tag_rp + AW'(1);
            rq_err[rq_wp] <= mem_rerr;
            rq_src[rq_wp] <= tagq[tag_rp];
         end
         if (err_push) begin
            rq_err[err_idx] <= 1'b1;
            rq_src[err_idx] <= err_src;
         end
         rq_wp    <= rq_wp + AW'(rvalid_eff) + AW'(err_push);
         rq_rp    <= rq_rp + AW'(pop);
         rq_count <= rq_count + CW'(rvalid_eff) + CW'(err_push) - CW'(pop);
      end
   end

   // Reply FIFO data storage; memory data first, then any error reply
   always_ff @(posedge clk) begin
      if (rvalid_eff) rq_data[rq_wp] <= mem_rdata;
      if (err_push)   rq_data[err_idx] <= 64'h0;
   end

endmodule

// File: tb/tb_ext_bridge.sv
// tb_ext_bridge: directed stimulus with a scoreboard. Stimulus pushes the
// expected memory beats and cache replies; a monitor pops and compares them
// as the bridge presents granted beats and popped replies.
module tb_ext_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } beat_t;

   typedef struct {
      logic [63:0] data;
      logic        err;
      logic        to;
   } reply_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        phi2 = 1'b0;
   logic [31:0] extaddr = '0;
   logic [63:0] extwdata = '0;
   logic [4:0]  extsz = '0;
   logic        extreq = 1'b0;
   logic        extwr = 1'b0;
   logic        extsrc = 1'b0;
   logic        extrdy, extreply, extreplyto, exterror;
   logic [63:0] extrdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        mem_rerr = 1'b0;
   logic        werr;

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int werr_count = 0;
   logic        gnt_en = 1'b1;
   logic        rv_en = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   beat_t       exp_beats [$];
   reply_t      exp_replies [$];
   logic [31:0] pending [$];
   beat_t       mb;
   reply_t      mr;
   logic [31:0] ra;

   ext_bridge #(.RQDEPTH(4)) dut (
      .clk(clk), .rst(rst), .phi2(phi2),
      .extaddr(extaddr), .extwdata(extwdata), .extsz(extsz),
      .extreq(extreq), .extwr(extwr), .extsrc(extsrc),
      .extrdy(extrdy), .extreply(extreply), .extreplyto(extreplyto),
      .extrdata(extrdata), .exterror(exterror),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
      .werr(werr)
   );

   // System clock
   always #5 clk = ~clk;

   // phi2 enable is high on every other clk edge
   always @(posedge clk) begin
      #1 phi2 = ~phi2;
   end

   function automatic logic [63:0] md(input logic [31:0] a);
      return {~a, a};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expBeat(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
      beat_t b;
      b.addr = a; b.we = w; b.wdata = d; b.wstrb = s;
      exp_beats.push_back(b);
   endtask

   task automatic expReply(input logic [63:0] d, input logic e, input logic t);
      reply_t r;
      r.data = d; r.err = e; r.to = t;
      exp_replies.push_back(r);
   endtask

   // Memory model: grants while enabled, returns reads in order
   always @(posedge clk) begin
      #2;
      mem_gnt = gnt_en && mem_req;
      if (rv_en && pending.size() > 0) begin
         ra = pending.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = md(ra);
         mem_rerr   = (ra == err_addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
         mem_rerr   = 1'b0;
      end
   end

   // Monitor: compare granted beats and popped replies against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && mem_gnt) begin
            beats_seen++;
            if (exp_beats.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got addr %h expected no beat", mem_addr);
            end else begin
               mb = exp_beats.pop_front();
               checkOutput("beat_addr", 64'(mem_addr), 64'(mb.addr));
               checkOutput("beat_we", 64'(mem_we), 64'(mb.we));
               checkOutput("beat_wstrb", 64'(mem_wstrb), 64'(mb.wstrb));
               if (mb.we) checkOutput("beat_wdata", mem_wdata, mb.wdata);
            end
            if (!mem_we) pending.push_back(mem_addr);
         end
         if (phi2 && extreply) begin
            if (exp_replies.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_reply: got data %h expected no reply", extrdata);
            end else begin
               mr = exp_replies.pop_front();
               checkOutput("reply_data", extrdata, mr.data);
               checkOutput("reply_err", 64'(exterror), 64'(mr.err));
               checkOutput("reply_to", 64'(extreplyto), 64'(mr.to));
            end
         end
         if (werr) werr_count++;
      end
   end

   task automatic sendCmd(input logic [31:0] a, input logic [4:0] s, input logic w,
                          input logic sr, input logic [63:0] d);
      logic ok;
      ok = 1'b0;
      @(posedge clk); #1;
      extaddr = a; extsz = s; extwr = w; extsrc = sr; extwdata = d; extreq = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (phi2 && extrdy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      extreq = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout: got no extrdy expected accept of addr %h", a);
      end
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((exp_beats.size() != 0 || exp_replies.size() != 0 || pending.size() != 0) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, 64'(exp_beats.size() + exp_replies.size() + pending.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      logic seen;
      int   w0, base, n;

      // single write, two bytes at offset 2
      expBeat(32'h100, 1'b1, 64'h0000_ABCD_0000_0000, 8'h30);
      sendCmd(32'h102, 5'd1, 1'b1, 1'b1, 64'hABCD);
      waitIdle("drain_single_write");

      // dcache 2-beat read, critical word first
      expBeat(32'h1008, 1'b0, '0, 8'h00);
      expBeat(32'h1000, 1'b0, '0, 8'h00);
      expReply(md(32'h1008), 1'b0, 1'b1);
      expReply(md(32'h1000), 1'b0, 1'b1);
      sendCmd(32'h1008, 5'd15, 1'b0, 1'b1, '0);
      @(negedge clk);
      checkOutput("issue_extrdy", 64'(extrdy), 64'd0);
      waitIdle("drain_dcache_read");

      // icache 4-beat read wrapping within the line
      expBeat(32'h2010, 1'b0, '0, 8'h00);
      expBeat(32'h2018, 1'b0, '0, 8'h00);
      expBeat(32'h2000, 1'b0, '0, 8'h00);
      expBeat(32'h2008, 1'b0, '0, 8'h00);
      expReply(md(32'h2010), 1'b0, 1'b0);
      expReply(md(32'h2018), 1'b0, 1'b0);
      expReply(md(32'h2000), 1'b0, 1'b0);
      expReply(md(32'h2008), 1'b0, 1'b0);
      sendCmd(32'h2010, 5'd31, 1'b0, 1'b0, '0);
      waitIdle("drain_icache_read");

      // 2-beat writeback with second data beat in WDATA2
      expBeat(32'h3000, 1'b1, 64'h1111_2222_3333_4444, 8'hFF);
      expBeat(32'h3008, 1'b1, 64'h5555_6666_7777_8888, 8'hFF);
      sendCmd(32'h3000, 5'd15, 1'b1, 1'b1, 64'h1111_2222_3333_4444);
      @(negedge clk);
      checkOutput("wdata2_extrdy", 64'(extrdy), 64'd1);
      sendCmd(32'h3000, 5'd15, 1'b1, 1'b1, 64'h5555_6666_7777_8888);
      waitIdle("drain_writeback");

      // credit stall with an errored beat
      rv_en = 1'b0;
      err_addr = 32'h5018;
      expBeat(32'h5010, 1'b0, '0, 8'h00);
      expBeat(32'h5018, 1'b0, '0, 8'h00);
      expBeat(32'h5000, 1'b0, '0, 8'h00);
      expBeat(32'h5008, 1'b0, '0, 8'h00);
      expBeat(32'h4008, 1'b0, '0, 8'h00);
      expReply(md(32'h5010), 1'b0, 1'b0);
      expReply(md(32'h5018), 1'b1, 1'b0);
      expReply(md(32'h5000), 1'b0, 1'b0);
      expReply(md(32'h5008), 1'b0, 1'b0);
      expReply(md(32'h4008), 1'b0, 1'b1);
      sendCmd(32'h5010, 5'd31, 1'b0, 1'b0, '0);
      sendCmd(32'h4008, 5'd7, 1'b0, 1'b1, '0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      checkOutput("stall_mem_req", 64'(seen), 64'd0);
      rv_en = 1'b1;
      waitIdle("drain_credit_stall");
      err_addr = 32'hFFFF_FFFF;

      // malformed read: error reply, no memory access
      expReply(64'h0, 1'b1, 1'b1);
      sendCmd(32'h6, 5'd3, 1'b0, 1'b1, '0);
      waitIdle("drain_bad_read");

      // malformed write: werr pulse, bridge stays ready
      w0 = werr_count;
      sendCmd(32'h40, 5'd9, 1'b1, 1'b0, 64'h1234);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("werr_pulse", 64'(werr_count - w0), 64'd1);
      checkOutput("bad_write_extrdy", 64'(extrdy), 64'd1);

      // reset in the middle of a 4-beat read
      rv_en = 1'b0;
      expBeat(32'h7000, 1'b0, '0, 8'h00);
      expBeat(32'h7008, 1'b0, '0, 8'h00);
      base = beats_seen;
      sendCmd(32'h7000, 5'd31, 1'b0, 1'b0, '0);
      n = 0;
      while (beats_seen < base + 2 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      gnt_en = 1'b0;
      checkOutput("mid_burst_beats", 64'(beats_seen - base), 64'd2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst_mid_extreply", 64'(extreply), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      gnt_en = 1'b1;
      rv_en = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (extreply) seen = 1'b1;
      end
      checkOutput("late_rvalid_ignored", 64'(seen), 64'd0);
      waitIdle("drain_after_reset");
   endtask

   // Main sequence: reset checks, directed scenarios, summary
   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_extrdy", 64'(extrdy), 64'd1);
      checkOutput("rst_extreply", 64'(extreply), 64'd0);
      checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst_werr", 64'(werr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog against a hung run
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
